// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding and default widths.
package timer_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int PRESC_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: counts 0..prescale while enabled and pulses tick for one cycle
// on the terminal value, then reloads 0. Clear has priority over enable.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    assign tick = enable && (presc_cnt == prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (clear) begin
            presc_cnt <= '0;
        end else if (enable) begin
            if (presc_cnt == prescale) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: owns counter enable/clear, period compare, FSM
// sequencing (IDLE/RUN/DONE) and the sticky irq/overrun flags.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               irq_ack,
    output logic [CNT_W-1:0]   count,
    output logic               running,
    output logic               done,
    output logic               irq,
    output logic               overrun,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [CNT_W-1:0]   period_lat;
    logic [PRESC_W-1:0] prescale_lat;
    logic               periodic_lat;

    logic do_start;
    logic presc_en;
    logic presc_clr;
    logic tick;
    logic expiry;

    // stop dominates a simultaneous start; neither lets a tick through that cycle
    assign do_start  = start && !stop;
    assign presc_clr = start || stop;
    assign presc_en  = (state == S_RUN) && !start && !stop;
    assign expiry    = tick && (count == period_lat);
    assign state_dbg = state;

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (presc_clr),
        .enable   (presc_en),
        .prescale (prescale_lat),
        .tick     (tick)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (do_start) state_next = S_RUN;
            S_RUN: begin
                if (stop)                         state_next = S_IDLE;
                else if (start)                   state_next = S_RUN;
                else if (expiry && !periodic_lat) state_next = S_DONE;
            end
            S_DONE: begin
                if (stop)       state_next = S_IDLE;
                else if (start) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            running      <= 1'b0;
            done         <= 1'b0;
            period_lat   <= '0;
            prescale_lat <= '0;
            periodic_lat <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == S_RUN);
            done    <= (state_next == S_DONE);
            if (do_start) begin
                period_lat   <= period;
                prescale_lat <= prescale;
                periodic_lat <= periodic;
            end
        end
    end

    // compare precedes increment, so count never passes period_lat (no wrap at max)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (do_start) begin
            count <= '0;
        end else if (tick) begin
            if (count == period_lat) begin
                if (periodic_lat) count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (expiry) begin
                irq <= 1'b1;
            end else if (irq_ack && !start && !stop) begin
                irq <= 1'b0;
            end
            if (do_start) begin
                overrun <= 1'b0;
            end else if (expiry && irq && !irq_ack) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: a per-cycle vector table plus
// hand-written reset and terminal-count sequences.
module tb_interval_timer_ctrl;

    localparam int CNT_W   = 32;
    localparam int PRESC_W = 8;

    typedef struct {
        logic               start;
        logic               stop;
        logic               periodic;
        logic [CNT_W-1:0]   period;
        logic [PRESC_W-1:0] prescale;
        logic               irq_ack;
        logic [CNT_W-1:0]   e_count;
        logic               e_running;
        logic               e_done;
        logic               e_irq;
        logic               e_overrun;
    } vec_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic               periodic;
    logic [CNT_W-1:0]   period;
    logic [PRESC_W-1:0] prescale;
    logic               irq_ack;
    logic [CNT_W-1:0]   count;
    logic               running;
    logic               done;
    logic               irq;
    logic               overrun;
    logic [1:0]         state_dbg;

    int   n_compared;
    int   n_mismatched;
    vec_t vecs[$];

    interval_timer_ctrl #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .period    (period),
        .prescale  (prescale),
        .irq_ack   (irq_ack),
        .count     (count),
        .running   (running),
        .done      (done),
        .irq       (irq),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [CNT_W-1:0] c, input logic r,
                              input logic d, input logic i, input logic o);
        check(name, 64'({count, running, done, irq, overrun}), 64'({c, r, d, i, o}));
    endtask

    function automatic void add(input logic st, input logic sp, input logic pm,
                                input logic [CNT_W-1:0] per, input logic [PRESC_W-1:0] ps,
                                input logic ack, input logic [CNT_W-1:0] ec, input logic er,
                                input logic ed, input logic ei, input logic eo);
        vec_t v;
        v.start = st; v.stop = sp; v.periodic = pm; v.period = per; v.prescale = ps;
        v.irq_ack = ack; v.e_count = ec; v.e_running = er; v.e_done = ed;
        v.e_irq = ei; v.e_overrun = eo;
        vecs.push_back(v);
    endfunction

    // non-start cycle: config inputs carry junk that must be ignored
    function automatic void idle(input logic ack, input logic [CNT_W-1:0] ec, input logic er,
                                 input logic ed, input logic ei, input logic eo);
        add(1'b0, 1'b0, 1'b1, 32'h0000_0005, 8'd7, ack, ec, er, ed, ei, eo);
    endfunction

    // driver: apply one cycle of inputs, sample 1 time unit after the edge
    task automatic drive_cycle(input logic st, input logic sp, input logic pm,
                               input logic [CNT_W-1:0] per, input logic [PRESC_W-1:0] ps,
                               input logic ack);
        start = st; stop = sp; periodic = pm; period = per; prescale = ps; irq_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_cycle();
        drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        period   = '0;
        prescale = '0;
        irq_ack  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_outs", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // reset mid-RUN at count 5, asserted away from any clock edge
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd10, 8'd0, 1'b0);
        repeat (5) quiet_cycle();
        check_outs("pre_reset_count5", 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset_outs", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("async_reset_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // one-shot, period 3, prescale 0
        add(1, 0, 0, 32'd3, 8'd0, 0,  32'd0, 1, 0, 0, 0);
        idle(0, 32'd1, 1, 0, 0, 0);
        idle(0, 32'd2, 1, 0, 0, 0);
        idle(0, 32'd3, 1, 0, 0, 0);
        idle(0, 32'd3, 0, 1, 1, 0);
        idle(0, 32'd3, 0, 1, 1, 0);
        idle(1, 32'd3, 0, 1, 0, 0);
        add(0, 1, 0, 32'd9, 8'd9, 0,  32'd3, 0, 0, 0, 0);
        // periodic, period 2, prescale 1: expiry every 6 cycles, acked each time
        add(1, 0, 1, 32'd2, 8'd1, 0,  32'd0, 1, 0, 0, 0);
        idle(0, 32'd0, 1, 0, 0, 0);
        idle(0, 32'd1, 1, 0, 0, 0);
        idle(0, 32'd1, 1, 0, 0, 0);
        idle(0, 32'd2, 1, 0, 0, 0);
        idle(0, 32'd2, 1, 0, 0, 0);
        idle(0, 32'd0, 1, 0, 1, 0);
        idle(1, 32'd0, 1, 0, 0, 0);
        idle(0, 32'd1, 1, 0, 0, 0);
        idle(0, 32'd1, 1, 0, 0, 0);
        idle(0, 32'd2, 1, 0, 0, 0);
        idle(0, 32'd2, 1, 0, 0, 0);
        idle(0, 32'd0, 1, 0, 1, 0);
        idle(1, 32'd0, 1, 0, 0, 0);
        // overrun: periodic, period 0, prescale 0
        add(1, 0, 1, 32'd0, 8'd0, 0,  32'd0, 1, 0, 0, 0);
        idle(0, 32'd0, 1, 0, 1, 0);
        idle(0, 32'd0, 1, 0, 1, 1);
        idle(1, 32'd0, 1, 0, 1, 1);
        add(0, 1, 0, 32'd0, 8'd0, 0,  32'd0, 0, 0, 1, 1);
        idle(1, 32'd0, 0, 0, 0, 1);
        // start+stop together in RUN: stop wins, count held, overrun kept
        add(1, 0, 0, 32'd10, 8'd0, 0, 32'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) idle(0, k, 1, 0, 0, 0);
        add(1, 1, 0, 32'd20, 8'd3, 0, 32'd7, 0, 0, 0, 0);
        idle(0, 32'd7, 0, 0, 0, 0);
        // restart during RUN at count 7 with a shorter period
        add(1, 0, 0, 32'd10, 8'd0, 0, 32'd0, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) idle(0, k, 1, 0, 0, 0);
        add(1, 0, 0, 32'd2, 8'd0, 0,  32'd0, 1, 0, 0, 0);
        idle(0, 32'd1, 1, 0, 0, 0);
        idle(0, 32'd2, 1, 0, 0, 0);
        idle(0, 32'd2, 0, 1, 1, 0);
        idle(0, 32'd2, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].start, vecs[i].stop, vecs[i].periodic, vecs[i].period,
                        vecs[i].prescale, vecs[i].irq_ack);
            check_outs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_running,
                       vecs[i].e_done, vecs[i].e_irq, vecs[i].e_overrun);
        end

        // terminal count: one-shot at period 0xFFFFFFFF, count preloaded near max
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'd0, 1'b0);
        start = 1'b0;
        force dut.count = 32'hFFFF_FFFD;
        @(negedge clk);
        release dut.count;
        @(posedge clk);
        #1;
        check_outs("term_fffe", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        quiet_cycle();
        check_outs("term_ffff", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        quiet_cycle();
        check_outs("term_expiry", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        quiet_cycle();
        check_outs("term_hold", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        check("term_state", 64'(state_dbg), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
